seg7_scan_driver: RTL and testbench

Multi-digit, time-multiplexed seven-segment display driver: the parametrised successor of the team's single-digit segment decoder. Accepts a packed vector of DIGITS hex nibbles plus decimal points, decodes 0–F, and scans one digit enable at a time at a programmable rate. Updates are tear-free: new values are committed only at frame boundaries. Optional per-digit blinking. Sits between the value-producing logic and the board's segment/anode pins.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_hex_decode.sv | 10 +
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns {a,b,c,d,e,f,g} (bit 6 = a, active-high) and hex-to-segment decode
package seg7_pkg;
   localparam logic [6:0] SEG_0   = 7'b1111110;
   localparam logic [6:0] SEG_1   = 7'b0110000;
   localparam logic [6:0] SEG_2   = 7'b1101101;
   localparam logic [6:0] SEG_3   = 7'b1111001;
   localparam logic [6:0] SEG_4   = 7'b0110011;
   localparam logic [6:0] SEG_5   = 7'b1011011;
   localparam logic [6:0] SEG_6   = 7'b1011111;
   localparam logic [6:0] SEG_7   = 7'b1110000;
   localparam logic [6:0] SEG_8   = 7'b1111111;
   localparam logic [6:0] SEG_9   = 7'b1111011;
   localparam logic [6:0] SEG_A   = 7'b1110111;
   localparam logic [6:0] SEG_B   = 7'b0011111;
   localparam logic [6:0] SEG_C   = 7'b1001110;
   localparam logic [6:0] SEG_D   = 7'b0111101;
   localparam logic [6:0] SEG_E   = 7'b1001111;
   localparam logic [6:0] SEG_F   = 7'b1000111;
   localparam logic [6:0] SEG_OFF = 7'b0000000;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: return SEG_0;
         4'h1: return SEG_1;
         4'h2: return SEG_2;
         4'h3: return SEG_3;
         4'h4: return SEG_4;
         4'h5: return SEG_5;
         4'h6: return SEG_6;
         4'h7: return SEG_7;
         4'h8: return SEG_8;
         4'h9: return SEG_9;
         4'hA: return SEG_A;
         4'hB: return SEG_B;
         4'hC: return SEG_C;
         4'hD: return SEG_D;
         4'hE: return SEG_E;
         default: return SEG_F;
      endcase
   endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble-to-segment decoder
//   hex in [3:0] nibble, seg out [6:0] active-high {a..g}
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb seg = hex_to_seg(hex);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed DIGITS-digit seven-segment driver with frame-synchronous updates
//   clk/rst (async, active-high); val/dp/blink digit data, load captures into staging;
//   seg/seg_dp/an drive the display pins (inverted when ACTIVE_LOW); frame_done pulses at frame wrap.
//   Define SEG7_BLINK_EN to build in per-digit blinking (BLINK_FRAMES frames per phase).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64,
   parameter bit ACTIVE_LOW   = 1'b0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] val,
   input  logic [DIGITS-1:0]   dp,
   input  logic [DIGITS-1:0]   blink,
   input  logic                load,
   output logic [6:0]          seg,
   output logic                seg_dp,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);

   logic [PW-1:0]       pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] stg_val_q, stg_val_d, dsp_val_q, dsp_val_d;
   logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, dsp_dp_q, dsp_dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d, dec_seg;
   logic [3:0]          nib;
   logic                seg_dp_q, seg_dp_d, frame_done_q;
   logic                tick, wrap, blank;

   // Staging feeds display through the same mux, so a load on the commit tick lands directly.
   always_comb begin
      tick      = pre_q == LAST_PRE;
      wrap      = tick && idx_q == LAST_IDX;
      pre_d     = tick ? '0 : pre_q + 1'b1;
      idx_d     = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
      stg_val_d = load ? val : stg_val_q;
      stg_dp_d  = load ? dp : stg_dp_q;
      dsp_val_d = wrap ? stg_val_d : dsp_val_q;
      dsp_dp_d  = wrap ? stg_dp_d : dsp_dp_q;
   end

   // Decode from next-state index/display so registered outputs line up with the new digit.
   assign nib = dsp_val_d[4*idx_d +: 4];

   seg7_hex_decode u_dec (
      .hex (nib),
      .seg (dec_seg)
   );

`ifdef SEG7_BLINK_EN
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic [DIGITS-1:0] stg_blk_q, stg_blk_d, dsp_blk_q, dsp_blk_d;
   logic              ph_q, ph_d, fend;

   always_comb begin
      fend      = fcnt_q == FW'(BLINK_FRAMES - 1);
      stg_blk_d = load ? blink : stg_blk_q;
      dsp_blk_d = wrap ? stg_blk_d : dsp_blk_q;
      fcnt_d    = wrap ? (fend ? '0 : fcnt_q + 1'b1) : fcnt_q;
      ph_d      = ph_q ^ (wrap && fend);
      blank     = ph_d && dsp_blk_d[idx_d];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fcnt_q    <= '0;
         ph_q      <= 1'b0;
         stg_blk_q <= '0;
         dsp_blk_q <= '0;
      end else begin
         fcnt_q    <= fcnt_d;
         ph_q      <= ph_d;
         stg_blk_q <= stg_blk_d;
         dsp_blk_q <= dsp_blk_d;
      end
`else
   logic unused_blink;
   assign unused_blink = ^{blink, 32'(BLINK_FRAMES)};
   assign blank = 1'b0;
`endif

   // Polarity is applied last so the registers hold pin-level values, reset included.
   always_comb begin
      seg_d    = {7{ACTIVE_LOW}} ^ (blank ? SEG_OFF : dec_seg);
      seg_dp_d = ACTIVE_LOW ^ (~blank & dsp_dp_d[idx_d]);
      an_d     = {DIGITS{ACTIVE_LOW}} ^ (DIGITS'(1) << idx_d);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pre_q        <= '0;
         idx_q        <= '0;
         stg_val_q    <= '0;
         stg_dp_q     <= '0;
         dsp_val_q    <= '0;
         dsp_dp_q     <= '0;
         seg_q        <= {7{ACTIVE_LOW}};
         seg_dp_q     <= ACTIVE_LOW;
         an_q         <= {DIGITS{ACTIVE_LOW}};
         frame_done_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         stg_val_q    <= stg_val_d;
         stg_dp_q     <= stg_dp_d;
         dsp_val_q    <= dsp_val_d;
         dsp_dp_q     <= dsp_dp_d;
         seg_q        <= seg_d;
         seg_dp_q     <= seg_dp_d;
         an_q         <= an_d;
         frame_done_q <= wrap;
      end

   assign seg        = seg_q;
   assign seg_dp     = seg_dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench, active-high and active-low instances side by side
module tb_seg7_scan_driver;
`ifdef SEG7_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
   logic [15:0] val = '0, prev;
   logic [3:0]  dp = '0, blink = '0;
   logic [6:0]  seg, seg_n;
   logic        seg_dp, seg_dp_n, fd, fd_n;
   logic [3:0]  an, an_n;
   int          total = 0, bad = 0;
   logic [6:0]  pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
   logic [15:0] sweep_val [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
   logic [3:0]  sweep_dp  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   always #5 clk = ~clk;

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .val(val), .dp(dp), .blink(blink), .load(load),
      .seg(seg), .seg_dp(seg_dp), .an(an), .frame_done(fd));

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .rst(rst), .val(val), .dp(dp), .blink(blink), .load(load),
      .seg(seg_n), .seg_dp(seg_dp_n), .an(an_n), .frame_done(fd_n));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic wait_frame;
      int n = 0;
      while (fd !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("frame_wait", fd, 1);
   endtask

   // Called on the first cycle of a frame; walks all 16 cycles and ends on the next frame's first cycle.
   task automatic check_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] bm);
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 4; c++) begin
            logic [6:0] es, esn;
            logic [3:0] ea, ean, nb;
            nb  = v[4*i +: 4];
            es  = bm[i] ? 7'b0 : pat[nb];
            ea  = 4'b1 << i;
            esn = ~es;
            ean = ~ea;
            check("frame_an", an, ea);
            check("frame_seg", seg, es);
            check("frame_dp", seg_dp, bm[i] ? 0 : d[i]);
            check("frame_done", fd, (i == 0 && c == 0) ? 1 : 0);
            if (c == 0) begin
               check("low_an", an_n, ean);
               check("low_seg", seg_n, esn);
            end
            @(negedge clk);
         end
      check("frame_period", fd, 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_an", an, 0);
      check("rst_seg", seg, 0);
      check("rst_dp", seg_dp, 0);
      check("rst_fd", fd, 0);
      check("rst_an_low", an_n, 4'hF);
      check("rst_seg_low", seg_n, 7'h7F);
      check("rst_dp_low", seg_dp_n, 1);
      rst = 1'b0;
      @(negedge clk);
      check("first_an", an, 4'b0001);
      check("first_seg", seg, pat[0]);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_an", an, 0);
      check("async_seg", seg, 0);
      check("async_dp", seg_dp, 0);
      check("async_fd", fd, 0);
      check("async_an_low", an_n, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      load = 1'b1; val = 16'h1234; dp = 4'b0100;
      @(negedge clk);
      load = 1'b0; val = 16'hFFFF; dp = 4'hF;
      wait_frame;
      check_frame(16'h1234, 4'b0100, 4'b0000);
      repeat (4) @(negedge clk);
      check("mid_an", an, 4'b0010);
      load = 1'b1; val = 16'hABCD; dp = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      prev = 16'h1234;
      for (int k = 5; k < 16; k++) begin
         check("tear_free", seg, pat[prev[4*(k/4) +: 4]]);
         @(negedge clk);
      end
      check_frame(16'hABCD, 4'b0000, 4'b0000);
      prev = 16'hABCD;
      for (int j = 0; j < 4; j++) begin
         repeat (15) @(negedge clk);
         check("pre_commit", seg, pat[prev[15:12]]);
         load = 1'b1; val = sweep_val[j]; dp = sweep_dp[j];
         @(negedge clk);
         load = 1'b0;
         check_frame(sweep_val[j], sweep_dp[j], 4'b0000);
         prev = sweep_val[j];
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      load = 1'b1; val = 16'h0080; dp = 4'b0011; blink = 4'b0001;
      @(negedge clk);
      load = 1'b0;
      wait_frame;
      for (int f = 1; f <= 5; f++)
         check_frame(16'h0080, 4'b0011, (BLINK && (f == 2 || f == 3)) ? 4'b0001 : 4'b0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
